// File: rtl/carrd_vseq_pkg.sv
// carrd_vseq_pkg: unit one-hot, FSM states, opcode constants and instruction classifier
package carrd_vseq_pkg;
  localparam int U_ALU = 0;
  localparam int U_MUL = 1;
  localparam int U_RED = 2;
  localparam int U_SLDU = 3;
  localparam int U_LSU = 4;
  localparam int U_CFG = 5;
  typedef logic [5:0] unit_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;
  localparam logic [6:0] OP_V = 7'b1010111;
  localparam logic [6:0] LOAD_FP = 7'b0000111;
  localparam logic [6:0] STORE_FP = 7'b0100111;
  localparam logic [2:0] F3_CFG = 3'b111;
  // Returns the one-hot target unit; all zeros marks an unclassifiable instruction.
  function automatic unit_t classify(input logic [31:0] i);
    unit_t u;
    u = '0;
    if (i[6:0] == LOAD_FP || i[6:0] == STORE_FP) u[U_LSU] = 1'b1;
    else if (i[6:0] == OP_V) begin
      if (i[14:12] == F3_CFG) u[U_CFG] = 1'b1;
      else if ((i[14:12] == 3'b010 || i[14:12] == 3'b110) && i[31:29] == 3'b100) u[U_MUL] = 1'b1;
      else if (i[14:12] == 3'b010 && i[31:29] == 3'b000) u[U_RED] = 1'b1;
      else if (i[31:27] == 5'b00111) u[U_SLDU] = 1'b1;
      else u[U_ALU] = 1'b1;
    end
    return u;
  endfunction
endpackage

// File: rtl/carrd_vseq_fifo.sv
// carrd_vseq_fifo: synchronous FIFO with occupancy count and synchronous clear
//   i_clr clears pointers/count; i_push ignored when full, i_pop ignored when empty;
//   o_data shows the head entry; o_count/o_full/o_empty report occupancy.
module carrd_vseq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/carrd_vseq.sv
// carrd_vseq: in-order vector instruction sequencer (FIFO, classify, issue, wait, writeback)
//   Inputs : clk, nrst (sync active-high reset), instr_valid/instr_in, flush, unit_done[4:0]
//   Outputs: instr_ready, issue_valid/issue_instr/issue_unit/issue_kill, wb_en/wb_vd,
//            cfg_wr_en, illegal, busy, fifo_count, timeout
//   Optional watchdog enabled by defining CARRD_VSEQ_TIMEOUT_EN.
module carrd_vseq
  import carrd_vseq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          instr_valid,
  input  logic [31:0]                   instr_in,
  output logic                          instr_ready,
  input  logic                          flush,
  output logic                          issue_valid,
  output logic [31:0]                   issue_instr,
  output logic [5:0]                    issue_unit,
  output logic                          issue_kill,
  input  logic [4:0]                    unit_done,
  output logic                          wb_en,
  output logic [4:0]                    wb_vd,
  output logic                          cfg_wr_en,
  output logic                          illegal,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout
);
  state_t r_state;
  logic [31:0] r_instr;
  unit_t r_unit;
  logic r_wb_wr, r_cfg, r_illegal;
  logic [31:0] w_head;
  logic w_full, w_empty, w_pop, w_done, w_timeout;
  unit_t w_cls;
  // Clear also covers reset, so the push of a flush/reset cycle is dropped.
  assign w_pop = r_state == S_IDLE && !w_empty;
  carrd_vseq_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .i_clr   (nrst || flush),
    .i_push  (instr_valid),
    .i_pop   (w_pop),
    .i_data  (instr_in),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign w_cls = classify(w_head);
  assign w_done = |(unit_done & r_unit[U_LSU:U_ALU]);
`ifdef CARRD_VSEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  // A done in the saturating cycle takes priority over the watchdog.
  assign w_timeout = r_state == S_WAIT && &r_cnt && !w_done;
  always_ff @(posedge clk) r_cnt <= (nrst || r_state != S_WAIT) ? '0 : r_cnt + TIMEOUT_W'(1);
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    r_illegal <= 1'b0;
    if (nrst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_unit <= '0;
      r_wb_wr <= 1'b0;
      r_cfg <= 1'b0;
    end else if (flush) r_state <= S_IDLE;
    else case (r_state)
      S_IDLE: if (!w_empty) begin
        if (w_cls == '0) r_illegal <= 1'b1;
        else begin
          r_instr <= w_head;
          r_unit <= w_cls;
          r_cfg <= w_cls[U_CFG];
          r_wb_wr <= !w_cls[U_CFG] && w_head[6:0] != STORE_FP;
          r_state <= w_cls[U_CFG] ? S_WB : S_ISSUE;
        end
      end
      S_ISSUE: r_state <= S_WAIT;
      S_WAIT: r_state <= w_done ? S_WB : w_timeout ? S_IDLE : S_WAIT;
      default: r_state <= S_IDLE;
    endcase
  end
  assign instr_ready = !w_full;
  assign issue_valid = r_state == S_ISSUE;
  assign issue_instr = r_instr;
  assign issue_unit = r_unit;
  assign issue_kill = (flush && !nrst && (r_state == S_ISSUE || r_state == S_WAIT)) || w_timeout;
  assign wb_en = r_state == S_WB && r_wb_wr;
  assign wb_vd = r_instr[11:7];
  assign cfg_wr_en = r_state == S_WB && r_cfg;
  assign illegal = r_illegal;
  assign busy = r_state != S_IDLE || !w_empty;
  assign timeout = w_timeout;
endmodule

// File: tb/tb_carrd_vseq.sv
// tb_carrd_vseq: directed self-checking bench for carrd_vseq
module tb_carrd_vseq;
  logic clk = 1'b0, nrst = 1'b1, instr_valid = 1'b0, flush = 1'b0;
  logic [31:0] instr_in = '0;
  logic [4:0] unit_done = '0;
  logic instr_ready, issue_valid, issue_kill, wb_en, cfg_wr_en, illegal, busy, timeout;
  logic [31:0] issue_instr;
  logic [5:0] issue_unit;
  logic [4:0] wb_vd;
  logic [2:0] fifo_count;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  carrd_vseq #(.FIFO_DEPTH(4), .TIMEOUT_W(4)) dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready), .flush(flush), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .issue_unit(issue_unit), .issue_kill(issue_kill),
    .unit_done(unit_done), .wb_en(wb_en), .wb_vd(wb_vd), .cfg_wr_en(cfg_wr_en),
    .illegal(illegal), .busy(busy), .fifo_count(fifo_count), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push1(input logic [31:0] v);
    instr_valid = 1'b1;
    instr_in = v;
    tick();
    instr_valid = 1'b0;
  endtask
  logic [31:0] ci [6] = '{32'h960021D7, 32'h96006157, 32'h020021D7, 32'h3A0042D7, 32'h02006157, 32'h02208057};
  logic [5:0]  cu [6] = '{6'b000010, 6'b000010, 6'b000100, 6'b001000, 6'b000001, 6'b000001};
  logic [4:0]  cv [6] = '{5'd3, 5'd2, 5'd3, 5'd5, 5'd2, 5'd0};
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_ready", instr_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unit", issue_unit, 0);
    chk("rst_instr", issue_instr, 0);
    chk("rst_pulses", {issue_valid, issue_kill, wb_en, cfg_wr_en, illegal, timeout}, 0);
    chk("rst_vd", wb_vd, 0);
    nrst = 1'b0;
    tick();
    // vadd, done on the 2nd WAIT cycle -> wb_en 5 cycles after accept
    push1(32'h02208057);
    chk("vadd_c1_count", fifo_count, 1);
    chk("vadd_c1_busy", busy, 1);
    tick();
    chk("vadd_c2_iv", issue_valid, 1);
    chk("vadd_c2_unit", issue_unit, 6'b000001);
    chk("vadd_c2_instr", issue_instr, 32'h02208057);
    tick();
    chk("vadd_c3_iv", issue_valid, 0);
    tick();
    unit_done = 5'b00001;
    chk("vadd_c4_wb", wb_en, 0);
    tick();
    unit_done = '0;
    chk("vadd_c5_wb", wb_en, 1);
    chk("vadd_c5_vd", wb_vd, 0);
    tick();
    chk("vadd_c6_wb", wb_en, 0);
    chk("vadd_c6_busy", busy, 0);
    // classification table, done on the first WAIT cycle -> wb_en 4 cycles after accept
    for (int i = 0; i < 6; i++) begin
      push1(ci[i]);
      tick();
      chk($sformatf("cls%0d_unit", i), issue_unit, cu[i]);
      chk($sformatf("cls%0d_iv", i), issue_valid, 1);
      tick();
      unit_done = cu[i][4:0];
      tick();
      unit_done = '0;
      chk($sformatf("cls%0d_wb", i), wb_en, 1);
      chk($sformatf("cls%0d_vd", i), wb_vd, cv[i]);
      tick();
      chk($sformatf("cls%0d_idle", i), busy, 0);
    end
    // vsetvli: cfg_wr_en 2 cycles after accept, never issued
    push1(32'h0D757057);
    chk("cfg_c1", cfg_wr_en, 0);
    tick();
    chk("cfg_c2", cfg_wr_en, 1);
    chk("cfg_c2_iv", issue_valid, 0);
    chk("cfg_c2_wb", wb_en, 0);
    tick();
    chk("cfg_c3", cfg_wr_en, 0);
    chk("cfg_c3_busy", busy, 0);
    // store: wrong-unit done ignored, LSU done completes with no writeback
    push1(32'h02050027);
    tick();
    chk("st_unit", issue_unit, 6'b010000);
    tick();
    unit_done = 5'b00001;
    tick();
    unit_done = 5'b10000;
    chk("st_c4_wb", wb_en, 0);
    tick();
    unit_done = '0;
    chk("st_c5_wb", wb_en, 0);
    chk("st_c5_busy", busy, 1);
    tick();
    chk("st_c6_busy", busy, 0);
    // load: done during ISSUE is ignored
    push1(32'h02050207);
    tick();
    unit_done = 5'b10000;
    tick();
    unit_done = '0;
    chk("ld_c3_wb", wb_en, 0);
    tick();
    chk("ld_c4_busy", busy, 1);
    unit_done = 5'b10000;
    tick();
    unit_done = '0;
    chk("ld_c5_wb", wb_en, 1);
    chk("ld_c5_vd", wb_vd, 4);
    tick();
    // illegal opcode dropped
    push1(32'h00000013);
    chk("ill_c1", illegal, 0);
    tick();
    chk("ill_c2", illegal, 1);
    chk("ill_c2_iv", issue_valid, 0);
    chk("ill_c2_busy", busy, 0);
    tick();
    chk("ill_c3", illegal, 0);
    // back-pressure behind an in-flight instruction, then flush
    push1(32'h02208057);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      instr_valid = 1'b1;
      instr_in = 32'h02208057 | (32'(k + 1) << 7);
      tick();
      chk($sformatf("bp_count%0d", k), fifo_count, 32'(k + 1));
    end
    chk("bp_ready_full", instr_ready, 0);
    instr_in = 32'h02208057 | (32'd5 << 7);
    tick();
    chk("bp_held_count", fifo_count, 4);
    chk("bp_held_ready", instr_ready, 0);
    unit_done = 5'b00001;
    tick();
    unit_done = '0;
    chk("bp_wb", wb_en, 1);
    tick();
    chk("bp_idle_count", fifo_count, 4);
    tick();
    chk("bp_pop_count", fifo_count, 3);
    chk("bp_pop_ready", instr_ready, 1);
    chk("bp_pop_iv", issue_valid, 1);
    chk("bp_pop_instr", issue_instr, 32'h022080D7);
    tick();
    instr_valid = 1'b0;
    chk("bp_5th_count", fifo_count, 4);
    flush = 1'b1;
    instr_valid = 1'b1;
    instr_in = 32'h02208057;
    #1;
    chk("fl_kill", issue_kill, 1);
    tick();
    flush = 1'b0;
    instr_valid = 1'b0;
    chk("fl_count", fifo_count, 0);
    chk("fl_busy", busy, 0);
    chk("fl_kill_off", issue_kill, 0);
    chk("fl_wb", wb_en, 0);
    tick();
    chk("fl_after", {wb_en, issue_valid, busy}, 0);
    // reset mid-operation: like flush but without issue_kill
    push1(32'h02208057);
    tick();
    tick();
    nrst = 1'b1;
    #1;
    chk("rm_kill", issue_kill, 0);
    tick();
    nrst = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_unit", issue_unit, 0);
    chk("rm_instr", issue_instr, 0);
    tick();
    chk("rm_after", {wb_en, issue_valid}, 0);
`ifdef CARRD_VSEQ_TIMEOUT_EN
    // watchdog fires in the 16th WAIT cycle
    push1(32'h02208057);
    tick();
    repeat (15) tick();
    chk("to_c17", timeout, 0);
    chk("to_c17_busy", busy, 1);
    tick();
    chk("to_c18", timeout, 1);
    chk("to_c18_kill", issue_kill, 1);
    tick();
    chk("to_c19", timeout, 0);
    chk("to_c19_busy", busy, 0);
    chk("to_c19_wb", wb_en, 0);
    // done in the saturating cycle wins
    push1(32'h02208057);
    tick();
    chk("to2_iv", issue_valid, 1);
    repeat (15) tick();
    tick();
    unit_done = 5'b00001;
    #1;
    chk("to2_c18", timeout, 0);
    tick();
    unit_done = '0;
    chk("to2_wb", wb_en, 1);
    tick();
`else
    // no watchdog: WAIT persists
    push1(32'h02208057);
    tick();
    repeat (20) tick();
    chk("nto_timeout", timeout, 0);
    chk("nto_busy", busy, 1);
    unit_done = 5'b00001;
    tick();
    unit_done = '0;
    chk("nto_wb", wb_en, 1);
    tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
